// File: rtl/load_store_unit_if.sv
// Request/response handshake and word-memory bus of the load/store unit.
// The slave modport is the LSU; the master modport is the core plus memory side.
interface load_store_unit_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;

   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_fault;

   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_we;
   logic [31:0] mem_rdata;

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_fault, mem_addr, mem_wdata, mem_we
   );

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_fault, mem_addr, mem_wdata, mem_we
   );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit in front of a word-only memory with combinational read
// and synchronous write. Sub-word loads extract and extend a lane; SB/SH do a
// read-modify-write over two cycles. Illegal requests are answered with a fault.
module load_store_unit #(
   parameter int unsigned WORDS = 64
) (
   input  logic              clk,
   input  logic              rst,
   load_store_unit_if.slave  bus
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LOAD  = 3'd1;
   localparam logic [2:0] S_MERGE = 3'd2;
   localparam logic [2:0] S_WRITE = 3'd3;
   localparam logic [2:0] S_RESP  = 3'd4;

   localparam logic [31:0] WORDS_L = 32'(WORDS);

   logic [2:0]  state_q,  state_d;
   logic [31:0] addr_q,   addr_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [31:0] wdata_q,  wdata_d;
   logic [31:0] rdata_q,  rdata_d;
   logic        fault_q,  fault_d;

   logic        req_fault;
   logic        accept;
   logic [7:0]  byte_lane;
   logic [15:0] half_lane;
   logic [31:0] load_data;
   logic [31:0] merge_data;

   assign accept = bus.req_valid && (state_q == S_IDLE);

   // Classify the incoming request: illegal width, misalignment or out of range.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      req_fault = 1'b0;
      if (bus.req_we) begin
         if (bus.req_funct3[2] || (bus.req_funct3 == 3'b011)) req_fault = 1'b1;
      end else begin
         if ((bus.req_funct3 == 3'b011) || (bus.req_funct3 == 3'b110) ||
             (bus.req_funct3 == 3'b111)) req_fault = 1'b1;
      end
      if ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) req_fault = 1'b1;
      if ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00)) req_fault = 1'b1;
      if ({2'b00, bus.req_addr[31:2]} >= WORDS_L) req_fault = 1'b1;
   end

   // Load path: pick the addressed byte/halfword and sign- or zero-extend it.
   always_comb begin
      byte_lane = bus.mem_rdata[{addr_q[1:0], 3'b000} +: 8];
      half_lane = bus.mem_rdata[{addr_q[1], 4'b0000} +: 16];
      case (funct3_q)
         3'b000:  load_data = {{24{byte_lane[7]}}, byte_lane};
         3'b001:  load_data = {{16{half_lane[15]}}, half_lane};
         3'b100:  load_data = {24'd0, byte_lane};
         3'b101:  load_data = {16'd0, half_lane};
         default: load_data = bus.mem_rdata;
      endcase
   end

   // Store merge: overwrite the addressed lane of the current word with store data.
   always_comb begin
      merge_data = bus.mem_rdata;
      if (funct3_q[1:0] == 2'b00) begin
         merge_data[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      end else begin
         merge_data[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      end
   end

   // Next-state and datapath register updates for the request sequencer.
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      funct3_d = funct3_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      fault_d  = fault_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               addr_d   = bus.req_addr;
               funct3_d = bus.req_funct3;
               wdata_d  = bus.req_wdata;
               rdata_d  = 32'd0;
               fault_d  = req_fault;
               if (req_fault)                       state_d = S_RESP;
               else if (!bus.req_we)                state_d = S_LOAD;
               else if (bus.req_funct3 == 3'b010)   state_d = S_WRITE;
               else                                 state_d = S_MERGE;
            end
         end
         S_LOAD: begin
            rdata_d = load_data;
            state_d = S_RESP;
         end
         S_MERGE: begin
            wdata_d = merge_data;
            state_d = S_WRITE;
         end
         S_WRITE: state_d = S_RESP;
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State registers with synchronous reset; reset drops any in-flight request.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
      if (rst) begin
         state_q  <= S_IDLE;
         addr_q   <= 32'd0;
         funct3_q <= 3'd0;
         wdata_q  <= 32'd0;
         rdata_q  <= 32'd0;
         fault_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         funct3_q <= funct3_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         fault_q  <= fault_d;
      end
   end

   assign bus.req_ready = (state_q == S_IDLE);
   assign bus.rsp_valid = (state_q == S_RESP);
   assign bus.rsp_rdata = rdata_q;
   assign bus.rsp_fault = fault_q;
   assign bus.mem_addr  = {addr_q[31:2], 2'b00};
   assign bus.mem_wdata = wdata_q;
   // A write in progress when reset arrives must not reach the memory.
   assign bus.mem_we    = (state_q == S_WRITE) && !rst;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: table of requests plus hand-written
// back-to-back and reset-during-store sequences; responses checked by scoreboard.
module tb_load_store_unit;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   load_store_unit_if bus ();

   load_store_unit #(.WORDS(64)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Word memory: combinational read, synchronous write.
   logic [31:0] mem [64];
   assign bus.mem_rdata = mem[bus.mem_addr[7:2]];
   always @(posedge clk) begin
      if (bus.mem_we) mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_err = 0;
   int we_cnt = 0;
   int rsp_cnt = 0;

   typedef struct {
      logic [31:0] rdata;
      logic        fault;
      int          acc;
      int          k;
   } exp_t;
   exp_t sb_q[$];

   typedef struct {
      string       name;
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_fault;
      int          exp_k;
      int          exp_we;
      int          mem_idx;
      logic [31:0] exp_mem;
   } vec_t;
   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Response monitor: every rsp_valid pulse must match the oldest expectation.
   always @(negedge clk) begin
      if (bus.mem_we) we_cnt++;
      if (bus.rsp_valid) begin
         exp_t e;
         rsp_cnt++;
         if (sb_q.size() == 0) begin
            check("unexpected_rsp", 32'd1, 32'd0);
         end else begin
            e = sb_q.pop_front();
            check("rsp_rdata", bus.rsp_rdata, e.rdata);
            check("rsp_fault", {31'd0, bus.rsp_fault}, {31'd0, e.fault});
            check("rsp_latency", 32'(cyc - e.acc), 32'(e.k));
         end
      end
   end

   task automatic add_vec(input string name, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_fault,
                          input int exp_k, input int exp_we, input int mem_idx,
                          input logic [31:0] exp_mem);
      vec_t v;
      v.name = name; v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
      v.exp_rdata = exp_rdata; v.exp_fault = exp_fault; v.exp_k = exp_k;
      v.exp_we = exp_we; v.mem_idx = mem_idx; v.exp_mem = exp_mem;
      vecs.push_back(v);
   endtask

   // Present one request, wait for acceptance, optionally record its expectation.
   task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input logic exp_fault, input int exp_k, input bit push);
      exp_t e;
      int   n;
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
      bus.req_addr = addr; bus.req_wdata = wdata;
      n = 0;
      while (!bus.req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!bus.req_ready) begin
         check("accept_timeout", 32'd1, 32'd0);
         bus.req_valid = 1'b0;
      end else begin
         @(posedge clk);
         #1;
         bus.req_valid = 1'b0;
         if (push) begin
            e.rdata = exp_rdata; e.fault = exp_fault; e.acc = cyc; e.k = exp_k;
            sb_q.push_back(e);
         end
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while (sb_q.size() != 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (sb_q.size() != 0) begin
         check("rsp_timeout", 32'(sb_q.size()), 32'd0);
         sb_q.delete();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   we0;
      int   rsp0;
      int   c0;
      exp_t e;

      for (int i = 0; i < 64; i++) mem[i] = 32'd0;
      mem[3] = 32'h8899AABB;
      bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'd0;
      bus.req_addr = 32'd0; bus.req_wdata = 32'd0;

      //          name        we    f3      addr   wdata         rdata         flt  k  we  idx  mem
      add_vec("lw_0c",    1'b0, 3'b010, 32'h0C, 32'h0,        32'h8899AABB, 1'b0, 1, 0, -1, 32'h0);
      add_vec("lb_0d",    1'b0, 3'b000, 32'h0D, 32'h0,        32'hFFFFFFAA, 1'b0, 1, 0, -1, 32'h0);
      add_vec("lbu_0d",   1'b0, 3'b100, 32'h0D, 32'h0,        32'h000000AA, 1'b0, 1, 0, -1, 32'h0);
      add_vec("lh_0e",    1'b0, 3'b001, 32'h0E, 32'h0,        32'hFFFF8899, 1'b0, 1, 0, -1, 32'h0);
      add_vec("lhu_0c",   1'b0, 3'b101, 32'h0C, 32'h0,        32'h0000AABB, 1'b0, 1, 0, -1, 32'h0);
      add_vec("sb_0d",    1'b1, 3'b000, 32'h0D, 32'h12345677, 32'h0,        1'b0, 2, 1,  3, 32'h889977BB);
      add_vec("sh_0e",    1'b1, 3'b001, 32'h0E, 32'hDEADBEEF, 32'h0,        1'b0, 2, 1,  3, 32'hBEEF77BB);
      add_vec("sw_10",    1'b1, 3'b010, 32'h10, 32'hCAFEF00D, 32'h0,        1'b0, 1, 1,  4, 32'hCAFEF00D);
      add_vec("f_lw_0e",  1'b0, 3'b010, 32'h0E, 32'h0,        32'h0,        1'b1, 0, 0,  3, 32'hBEEF77BB);
      add_vec("f_sh_0f",  1'b1, 3'b001, 32'h0F, 32'h11112222, 32'h0,        1'b1, 0, 0,  3, 32'hBEEF77BB);
      add_vec("f_lb_100", 1'b0, 3'b000, 32'h100, 32'h0,       32'h0,        1'b1, 0, 0,  0, 32'h0);
      add_vec("f_ld_011", 1'b0, 3'b011, 32'h0C, 32'h0,        32'h0,        1'b1, 0, 0,  3, 32'hBEEF77BB);
      add_vec("lw_10",    1'b0, 3'b010, 32'h10, 32'h0,        32'hCAFEF00D, 1'b0, 1, 0, -1, 32'h0);

      // Reset state, sampled while reset is still asserted.
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
      check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      check("rst_rsp_fault", {31'd0, bus.rsp_fault}, 32'd0);
      check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
      check("rst_mem_we",    {31'd0, bus.mem_we}, 32'd0);
      check("rst_mem_addr",  bus.mem_addr, 32'd0);
      check("rst_mem_wdata", bus.mem_wdata, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_ready", {31'd0, bus.req_ready}, 32'd1);

      // Table-driven requests.
      foreach (vecs[i]) begin
         we0 = we_cnt;
         issue(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
               vecs[i].exp_rdata, vecs[i].exp_fault, vecs[i].exp_k, 1'b1);
         wait_idle();
         @(negedge clk);
         check({vecs[i].name, "_we_pulses"}, 32'(we_cnt - we0), 32'(vecs[i].exp_we));
         if (vecs[i].mem_idx >= 0)
            check({vecs[i].name, "_mem"}, mem[vecs[i].mem_idx], vecs[i].exp_mem);
      end

      // Back-to-back loads with req_valid held high.
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'b010;
      bus.req_addr = 32'h0C; bus.req_wdata = 32'd0;
      check("b2b_ready_first", {31'd0, bus.req_ready}, 32'd1);
      @(posedge clk);
      #1;
      c0 = cyc;
      e.rdata = 32'hBEEF77BB; e.fault = 1'b0; e.acc = cyc; e.k = 1;
      sb_q.push_back(e);
      bus.req_addr = 32'h10;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         check("b2b_ready_low", {31'd0, bus.req_ready}, 32'd0);
      end
      @(negedge clk);
      check("b2b_ready_high", {31'd0, bus.req_ready}, 32'd1);
      @(posedge clk);
      #1;
      check("b2b_accept_edge", 32'(cyc - c0), 32'd3);
      e.rdata = 32'hCAFEF00D; e.fault = 1'b0; e.acc = cyc; e.k = 1;
      sb_q.push_back(e);
      bus.req_valid = 1'b0;
      wait_idle();

      // Reset while the SB sits in MERGE: nothing written, no response.
      @(negedge clk);
      we0 = we_cnt;
      rsp0 = rsp_cnt;
      issue(1'b1, 3'b000, 32'h0C, 32'h000000FF, 32'h0, 1'b0, 0, 1'b0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_mid_ready", {31'd0, bus.req_ready}, 32'd1);
      repeat (4) @(negedge clk);
      check("rst_mid_we", 32'(we_cnt - we0), 32'd0);
      check("rst_mid_rsp", 32'(rsp_cnt - rsp0), 32'd0);
      check("rst_mid_mem", mem[3], 32'hBEEF77BB);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
